// File: rtl/soc_system_pio_pkg.sv
// Shared constants for the parametrised PIO slave: register word addresses
// and edge-capture selection codes.
package soc_system_pio_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/soc_system_pio_if.sv
// Avalon-MM slave bus bundle for the PIO: zero-wait-state, readdata is
// combinational from address.
interface soc_system_pio_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/soc_system_pio_sync.sv
// Vector 2-flop synchroniser for asynchronous inputs; resets to zero.
module soc_system_pio_sync #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/soc_system_pio_ext.sv
// Parametrised Avalon-MM PIO: direction control, atomic set/clear, synchronised
// inputs, per-bit edge capture and a maskable registered interrupt.
module soc_system_pio_ext
  import soc_system_pio_pkg::*;
#(
  parameter int               WIDTH       = 5,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               EDGE_TYPE   = EDGE_RISING
) (
  input  logic              clk,
  input  logic              reset,
  soc_system_pio_if.slave   avs,
  input  logic [WIDTH-1:0]  in_port,
  output logic [WIDTH-1:0]  out_port,
  output logic [WIDTH-1:0]  out_en,
  output logic              irq
);

  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] sync_d;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] cap_clr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rd_val;
  logic             wr_en;
  logic             irq_q;

  soc_system_pio_sync #(.WIDTH(WIDTH)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (in_port),
    .q     (sync_in)
  );

  assign wr_en   = avs.chipselect && !avs.write_n;
  assign wdata   = avs.writedata[WIDTH-1:0];
  assign cap_clr = (wr_en && avs.address == ADDR_EDGECAP) ? wdata : '0;

  always_comb begin
    edge_det = sync_in & ~sync_d;
    case (EDGE_TYPE)
      EDGE_FALLING: edge_det = ~sync_in & sync_d;
      EDGE_ANY:     edge_det = sync_in ^ sync_d;
      default:      edge_det = sync_in & ~sync_d;
    endcase
  end

  // A new edge is OR'd in after the clear so it survives a simultaneous W1C.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out <= RESET_VALUE;
      dir      <= '0;
      irq_mask <= '0;
      edge_cap <= '0;
      sync_d   <= '0;
      irq_q    <= 1'b0;
    end else begin
      sync_d   <= sync_in;
      edge_cap <= (edge_cap & ~cap_clr) | edge_det;
      irq_q    <= |(edge_cap & irq_mask);
      if (wr_en) begin
        case (avs.address)
          ADDR_DATA:    data_out <= wdata;
          ADDR_DIR:     dir      <= wdata;
          ADDR_IRQMASK: irq_mask <= wdata;
          ADDR_OUTSET:  data_out <= data_out | wdata;
          ADDR_OUTCLR:  data_out <= data_out & ~wdata;
          default:      ;
        endcase
      end
    end
  end

  always_comb begin
    rd_val = '0;
    case (avs.address)
      ADDR_DATA:    rd_val = (sync_in & ~dir) | (data_out & dir);
      ADDR_DIR:     rd_val = dir;
      ADDR_IRQMASK: rd_val = irq_mask;
      ADDR_EDGECAP: rd_val = edge_cap;
      default:      rd_val = '0;
    endcase
  end

  assign avs.readdata = 32'(rd_val);
  assign out_port     = data_out;
  assign out_en       = dir;
  assign irq          = irq_q;

endmodule
